// File: rtl/imm_decode_stage_pkg.sv
// rtl/imm_decode_stage_pkg.sv - opcodes, format codes and helpers shared by the immediate-decode stage
package imm_decode_stage_pkg;

   localparam logic [6:0] OPC_LOAD      = 7'b0000011;
   localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
   localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
   localparam logic [6:0] OPC_STORE     = 7'b0100011;
   localparam logic [6:0] OPC_OP        = 7'b0110011;
   localparam logic [6:0] OPC_LUI       = 7'b0110111;
   localparam logic [6:0] OPC_OP_32     = 7'b0111011;
   localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
   localparam logic [6:0] OPC_JALR      = 7'b1100111;
   localparam logic [6:0] OPC_JAL       = 7'b1101111;
   localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

   typedef enum logic [2:0] {
      FMT_NONE = 3'd0,
      FMT_I    = 3'd1,
      FMT_S    = 3'd2,
      FMT_B    = 3'd3,
      FMT_U    = 3'd4,
      FMT_J    = 3'd5,
      FMT_CSR  = 3'd6
   } fmt_e;

   function automatic bit xlen_legal(input int xlen);
      return (xlen == 32) || (xlen == 64);
   endfunction

   // Every immediate is first formed as a 32-bit value; widening to XLEN copies bit 31.
   function automatic logic [63:0] sext32(input logic [31:0] v);
      return {{32{v[31]}}, v};
   endfunction

endpackage

// File: rtl/imm_decode_stage_imm_extract.sv
// rtl/imm_decode_stage_imm_extract.sv - combinational immediate/format extraction; IMM_CSR_EN enables the CSR immediate format
module imm_extract
   import imm_decode_stage_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     instr_i,
   input  logic            is_rv64_i,
   output logic [XLEN-1:0] imm_o,
   output fmt_e            fmt_o,
   output logic            illegal_o
);

   logic [6:0]  opcode;
   logic [31:0] imm_i32;
   logic [31:0] imm_s32;
   logic [31:0] imm_b32;
   logic [31:0] imm_u32;
   logic [31:0] imm_j32;
   logic [31:0] imm32;

   assign opcode  = instr_i[6:0];
   assign imm_i32 = {{20{instr_i[31]}}, instr_i[31:20]};
   assign imm_s32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
   assign imm_b32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
   assign imm_u32 = {instr_i[31:12], 12'b0};
   assign imm_j32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

   always_comb begin
      imm32     = '0;
      fmt_o     = FMT_NONE;
      illegal_o = 1'b0;
      case (opcode)
         OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
            fmt_o = FMT_I;
            imm32 = imm_i32;
         end
         OPC_OP_IMM_32: begin
            if (is_rv64_i) begin
               fmt_o = FMT_I;
               imm32 = imm_i32;
            end else begin
               illegal_o = 1'b1;
            end
         end
         OPC_STORE: begin
            fmt_o = FMT_S;
            imm32 = imm_s32;
         end
         OPC_BRANCH: begin
            fmt_o = FMT_B;
            imm32 = imm_b32;
         end
         OPC_LUI, OPC_AUIPC: begin
            fmt_o = FMT_U;
            imm32 = imm_u32;
         end
         OPC_JAL: begin
            fmt_o = FMT_J;
            imm32 = imm_j32;
         end
         OPC_OP: begin
            fmt_o = FMT_NONE;
         end
         OPC_OP_32: begin
            illegal_o = !is_rv64_i;
         end
         OPC_SYSTEM: begin
`ifdef IMM_CSR_EN
            if (instr_i[14]) begin
               fmt_o = FMT_CSR;
               imm32 = {27'd0, instr_i[19:15]};
            end else begin
               fmt_o = FMT_I;
               imm32 = imm_i32;
            end
`else
            fmt_o = FMT_I;
            imm32 = imm_i32;
`endif
         end
         default: begin
            illegal_o = 1'b1;
         end
      endcase
      // Compressed-quadrant encodings are not decodable here.
      if (instr_i[1:0] != 2'b11) begin
         imm32     = '0;
         fmt_o     = FMT_NONE;
         illegal_o = 1'b1;
      end
   end

   assign imm_o = XLEN'(sext32(imm32));

endmodule

// File: rtl/imm_decode_stage.sv
// rtl/imm_decode_stage.sv - single-entry registered immediate-decode stage with valid/ready handshake and PC-relative target
module imm_decode_stage
   import imm_decode_stage_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [31:0]     out_instr,
   output logic [XLEN-1:0] out_pc,
   output logic [XLEN-1:0] out_imm,
   output logic [2:0]      out_fmt,
   output logic [XLEN-1:0] out_target,
   output logic            out_illegal
);

   if (!xlen_legal(XLEN)) begin : g_bad_xlen
      $error("imm_decode_stage: XLEN must be 32 or 64");
   end

   localparam logic IS_RV64 = (XLEN == 64);

   logic [XLEN-1:0] dec_imm;
   fmt_e            dec_fmt;
   logic            dec_illegal;
   logic            accept;
   logic            valid_d;
   logic [XLEN-1:0] target_d;

   logic            valid_q;
   logic [31:0]     instr_q;
   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] imm_q;
   fmt_e            fmt_q;
   logic [XLEN-1:0] target_q;
   logic            illegal_q;

   imm_extract #(
      .XLEN (XLEN)
   ) u_imm_extract (
      .instr_i   (in_instr),
      .is_rv64_i (IS_RV64),
      .imm_o     (dec_imm),
      .fmt_o     (dec_fmt),
      .illegal_o (dec_illegal)
   );

   assign in_ready = !valid_q || out_ready;
   assign accept   = in_valid && in_ready && !flush;
   assign target_d = in_pc + dec_imm;

   always_comb begin
      valid_d = valid_q;
      if (flush) begin
         valid_d = 1'b0;
      end else if (accept) begin
         valid_d = 1'b1;
      end else if (out_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q   <= 1'b0;
         instr_q   <= '0;
         pc_q      <= '0;
         imm_q     <= '0;
         fmt_q     <= FMT_NONE;
         target_q  <= '0;
         illegal_q <= 1'b0;
      end else begin
         valid_q <= valid_d;
         if (accept) begin
            instr_q   <= in_instr;
            pc_q      <= in_pc;
            imm_q     <= dec_imm;
            fmt_q     <= dec_fmt;
            target_q  <= target_d;
            illegal_q <= dec_illegal;
         end
      end
   end

   assign out_valid   = valid_q;
   assign out_instr   = instr_q;
   assign out_pc      = pc_q;
   assign out_imm     = imm_q;
   assign out_fmt     = fmt_q;
   assign out_target  = target_q;
   assign out_illegal = illegal_q;

endmodule
